// File: rtl/game_status_tracker_if.sv
// game_status_tracker_if: groups the gameplay event inputs and the status
// outputs of game_status_tracker into one bundle.
//   master : the side that raises game events and reads status (game logic / bench)
//   slave  : the status tracker itself
// Optional macro HISCORE_EN adds the hi_score status field.
interface game_status_tracker_if;
  // gameplay events and level inputs
  logic        frame_tick;
  logic        start;
  logic        player_hit;
  logic        alien_kill;
  logic [2:0]  alien_row;
  logic        alien_at_bottom;
  logic [5:0]  aliens_left;

  // status outputs
  logic        finished;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [3:0]  wave;
  logic        invuln;
  logic        new_wave;
`ifdef HISCORE_EN
  logic [15:0] hi_score;
`endif

  modport master (
    output frame_tick, start, player_hit, alien_kill, alien_row,
    output alien_at_bottom, aliens_left,
`ifdef HISCORE_EN
    input  hi_score,
`endif
    input  finished, lives, score, wave, invuln, new_wave
  );

  modport slave (
    input  frame_tick, start, player_hit, alien_kill, alien_row,
    input  alien_at_bottom, aliens_left,
`ifdef HISCORE_EN
    output hi_score,
`endif
    output finished, lives, score, wave, invuln, new_wave
  );
endinterface

// File: rtl/game_status_tracker.sv
// game_status_tracker: lives / BCD score / wave bookkeeping for the game.
// States: IDLE -> PLAYING <-> RESPAWN, PLAYING/RESPAWN -> WAVE_CLEAR -> PLAYING,
// PLAYING/RESPAWN -> OVER; start restarts the game from any state.
// Optional macro HISCORE_EN adds a BCD high-score register that survives
// start and clears only on reset.
module game_status_tracker #(
  parameter int START_LIVES       = 3,
  parameter int RESPAWN_FRAMES    = 120,
  parameter int WAVE_PAUSE_FRAMES = 90
) (
  input  logic                  clk,
  input  logic                  reset,
  game_status_tracker_if.slave  bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] PLAYING    = 3'd1;
  localparam logic [2:0] RESPAWN    = 3'd2;
  localparam logic [2:0] WAVE_CLEAR = 3'd3;
  localparam logic [2:0] OVER       = 3'd4;

  localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
  localparam logic [7:0] RESPAWN_END = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] PAUSE_END   = 8'(WAVE_PAUSE_FRAMES);
  localparam logic [3:0] WAVE_MAX    = 4'd15;

  logic [2:0]  state_reg,    state_next;
  logic [1:0]  lives_reg,    lives_next;
  logic [15:0] score_reg,    score_next;
  logic [3:0]  wave_reg,     wave_next;
  logic [7:0]  cnt_reg,      cnt_next;
  logic        new_wave_reg, new_wave_next;
  logic        finished_reg;
  logic        invuln_reg;

  logic [7:0]  cnt_inc;
  logic [3:0]  kill_tens;
  logic [4:0]  carry;
  logic [15:0] bcd_sum;
  logic [15:0] score_sat;

  // points for the killed alien, expressed as the BCD tens digit
  always_comb begin
    kill_tens = 4'd1;
    if (bus.alien_row == 3'd0) begin
      kill_tens = 4'd3;
    end else if (bus.alien_row <= 3'd2) begin
      kill_tens = 4'd2;
    end
  end

  // four-digit BCD ripple adder; the addend only ever lands on the tens digit
  assign carry[0] = 1'b0;
  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
    logic [3:0] addend;
    logic [4:0] raw;
    assign addend   = (gi == 1) ? kill_tens : 4'd0;
    assign raw      = {1'b0, score_reg[gi*4 +: 4]} + {1'b0, addend} + {4'd0, carry[gi]};
    assign carry[gi+1] = (raw > 5'd9);
    assign bcd_sum[gi*4 +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
  end

  // a carry out of the thousands digit means the true sum passed 9999
  assign score_sat = carry[4] ? 16'h9999 : bcd_sum;

  assign cnt_inc = cnt_reg + 8'd1;

  // next-state and bookkeeping; start overrides everything in every state
  always_comb begin
    state_next    = state_reg;
    lives_next    = lives_reg;
    score_next    = score_reg;
    wave_next     = wave_reg;
    cnt_next      = cnt_reg;
    new_wave_next = 1'b0;

    if (bus.start) begin
      state_next    = PLAYING;
      lives_next    = LIVES_INIT;
      score_next    = 16'h0000;
      wave_next     = 4'd1;
      cnt_next      = 8'd0;
      new_wave_next = 1'b1;
    end else begin
      case (state_reg)
        PLAYING, RESPAWN: begin
          // kills always score here, even when the same cycle ends the wave or game
          if (bus.alien_kill) begin
            score_next = score_sat;
          end
          if (bus.alien_at_bottom) begin
            lives_next = 2'd0;
            state_next = OVER;
          end else if ((state_reg == PLAYING) && bus.player_hit) begin
            if (lives_reg > 2'd1) begin
              lives_next = lives_reg - 2'd1;
              cnt_next   = 8'd0;
              state_next = RESPAWN;
            end else begin
              lives_next = 2'd0;
              state_next = OVER;
            end
          end else if (bus.aliens_left == 6'd0) begin
            cnt_next   = 8'd0;
            state_next = WAVE_CLEAR;
          end else if ((state_reg == RESPAWN) && bus.frame_tick) begin
            cnt_next = cnt_inc;
            if (cnt_inc == RESPAWN_END) begin
              cnt_next   = 8'd0;
              state_next = PLAYING;
            end
          end
        end

        WAVE_CLEAR: begin
          // gameplay events are ignored while the grid is being reloaded
          if (bus.frame_tick) begin
            cnt_next = cnt_inc;
            if (cnt_inc == PAUSE_END) begin
              cnt_next      = 8'd0;
              state_next    = PLAYING;
              new_wave_next = 1'b1;
              if (wave_reg != WAVE_MAX) begin
                wave_next = wave_reg + 4'd1;
              end
            end
          end
        end

        IDLE, OVER: begin
          // only start leaves these states
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // state registers; status flags are registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      lives_reg    <= 2'd0;
      score_reg    <= 16'h0000;
      wave_reg     <= 4'd0;
      cnt_reg      <= 8'd0;
      new_wave_reg <= 1'b0;
      finished_reg <= 1'b0;
      invuln_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lives_reg    <= lives_next;
      score_reg    <= score_next;
      wave_reg     <= wave_next;
      cnt_reg      <= cnt_next;
      new_wave_reg <= new_wave_next;
      finished_reg <= (state_next == OVER);
      invuln_reg   <= (state_next == RESPAWN);
    end
  end

  assign bus.finished = finished_reg;
  assign bus.lives    = lives_reg;
  assign bus.score    = score_reg;
  assign bus.wave     = wave_reg;
  assign bus.invuln   = invuln_reg;
  assign bus.new_wave = new_wave_reg;

`ifdef HISCORE_EN
  logic [15:0] hi_score_reg;

  // BCD digits are ordered, so a plain magnitude compare is a valid BCD compare
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_score_reg <= 16'h0000;
    end else if ((state_reg == OVER) && (score_reg > hi_score_reg)) begin
      hi_score_reg <= score_reg;
    end
  end

  assign bus.hi_score = hi_score_reg;
`endif

endmodule

// File: doc/game_status_tracker.md
GAME_STATUS_TRACKER -- requirements
Module: game_status_tracker

Interface
REQ-001 Parameter START_LIVES, default 3: lives loaded at game start, range 1..3.
REQ-002 Parameter RESPAWN_FRAMES, default 120: invulnerability length in frame ticks after a player hit, range 1..255.
REQ-003 Parameter WAVE_PAUSE_FRAMES, default 90: pause length in frame ticks between waves, range 1..255.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame; drives all frame counters.
REQ-007 start  in  1  one-cycle pulse from gameFSM (GAME_START); begins a new game.
REQ-008 player_hit  in  1  one-cycle pulse; an alien shot hit the player.
REQ-009 alien_kill  in  1  one-cycle pulse; a player shot destroyed an alien.
REQ-010 alien_row  in  3  row of the killed alien (0 = top), qualified by alien_kill.
REQ-011 alien_at_bottom  in  1  level; the alien formation reached the player row.
REQ-012 aliens_left  in  6  live alien count for the current wave (0..55).
REQ-013 finished  out  1  level; game over, consumed by gameFSM.
REQ-014 lives  out  2  remaining lives.
REQ-015 score  out  16  four BCD digits, score[15:12] most significant.
REQ-016 wave  out  4  current wave number, 1..15.
REQ-017 invuln  out  1  high while in RESPAWN.
REQ-018 new_wave  out  1  one-cycle pulse; the alien grid must be reloaded.
REQ-019 hi_score  out  16  BCD high score; present only when HISCORE_EN is defined.

Function
REQ-020 The FSM SHALL have states IDLE, PLAYING, RESPAWN, WAVE_CLEAR, and OVER.
REQ-021 start SHALL, in any state, on the next edge: score=0, lives=START_LIVES, wave=1, frame counter=0, finished=0, state=PLAYING, new_wave=1 for one cycle.
REQ-022 start SHALL take priority over every other input in the same cycle.
REQ-023 In PLAYING or RESPAWN, alien_kill SHALL add 30 (row 0), 20 (rows 1-2), or 10 (rows 3-7) to score in BCD, one cycle after the pulse.
REQ-024 BCD addition SHALL saturate at 9999; no digit ever exceeds 9.
REQ-025 In PLAYING, player_hit with lives>1 SHALL decrement lives, clear the frame counter, and enter RESPAWN.
REQ-026 In PLAYING, player_hit with lives==1 SHALL set lives=0 and enter OVER.
REQ-027 In RESPAWN, player_hit SHALL be ignored.
REQ-028 RESPAWN SHALL return to PLAYING on the frame_tick that makes the counter equal RESPAWN_FRAMES.
REQ-029 In PLAYING or RESPAWN, alien_at_bottom=1 SHALL set lives=0 and enter OVER; this takes priority over player_hit and aliens_left==0.
REQ-030 In PLAYING or RESPAWN, aliens_left==0 (with no higher-priority event) SHALL clear the frame counter and enter WAVE_CLEAR; a same-cycle alien_kill is still scored.
REQ-031 In WAVE_CLEAR, player_hit, alien_kill and alien_at_bottom SHALL be ignored.
REQ-032 After WAVE_PAUSE_FRAMES frame ticks, WAVE_CLEAR SHALL increment wave (saturating at 15), pulse new_wave, and enter PLAYING.
REQ-033 In OVER, finished SHALL be 1 and held until start; every other input is ignored.
REQ-034 In IDLE, all inputs except start SHALL be ignored.
REQ-035 invuln SHALL equal (state==RESPAWN), registered.

Reset
REQ-036 Asserted reset SHALL immediately force state=IDLE, finished=0, lives=0, score=0, wave=0, invuln=0, new_wave=0, and frame counter=0, regardless of clk.
REQ-037 hi_score SHALL reset to 0 only on reset, never on start.
REQ-038 Reset asserted mid-RESPAWN or mid-WAVE_CLEAR SHALL abandon the countdown; there is no resumed state.

Configuration
REQ-039 With HISCORE_EN defined, hi_score SHALL be present and SHALL load score one cycle after entry to OVER when score > hi_score (BCD compare).
REQ-040 Without HISCORE_EN, the hi_score port, register and comparator SHALL be absent; all other behaviour is identical.

Verification
REQ-041 Reset, start, then 3 kills at rows 0, 2, 4 -> score=0x0060, lives=3, wave=1, new_wave pulsed once after start.
REQ-042 START_LIVES=3, hit -> lives=2, invuln=1; second hit within 120 ticks -> lives stays 2; after 120 ticks invuln=0; hits bring lives 1 then 0, finished=1.
REQ-043 score=0x9990, row-0 kill -> score=0x9999; a further kill -> 0x9999.
REQ-044 aliens_left=0 and alien_kill in the same cycle -> kill scored, WAVE_CLEAR entered; after 90 ticks wave=2 and new_wave pulses; alien_at_bottom during the pause has no effect.
REQ-045 alien_at_bottom and player_hit in the same cycle with lives=3 -> lives=0, finished=1; later start -> finished=0, score=0, lives=3.
REQ-046 HISCORE_EN defined: game 1 ends at 0x0150, game 2 at 0x0090 -> hi_score=0x0150 after both games.
